// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

    localparam int unsigned PC_INC = 32'd4;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer holding a redirect target that arrived while fetch was stalled.
// Once full, later captures are ignored so the oldest redirect wins.
module pc_redirect_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            capture_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] target_i,
    output logic            valid_o,
    output logic [XLEN-1:0] target_o
);

    logic            valid_q;
    logic [XLEN-1:0] target_q;

    // Pending-entry register: clear dominates, capture only fills an empty slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            target_q <= {XLEN{1'b0}};
        end else if (clear_i) begin
            valid_q  <= 1'b0;
        end else if (capture_i && !valid_q) begin
            valid_q  <= 1'b1;
            target_q <= target_i;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot sequencing, trap/redirect/stall priority, deferred redirects.
// Define PC_MISALIGN_TRAP_EN to turn misaligned redirect targets into traps.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            redirect_pending_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] bad_addr_o
);

    localparam logic [XLEN-1:0] PC_INC_W   = XLEN'(PC_INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] bad_q, bad_d;
    logic            buf_capture_s, buf_clear_s, buf_valid_s;
    logic [XLEN-1:0] buf_target_s;
    logic            load_req_s;
    logic [XLEN-1:0] load_tgt_s;

    pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
        .clk       (clk),
        .reset     (reset),
        .capture_i (buf_capture_s),
        .clear_i   (buf_clear_s),
        .target_i  (redirect_target_i),
        .valid_o   (buf_valid_s),
        .target_o  (buf_target_s)
    );

    // Next-state and next-PC selection; a redirect load is resolved after the case.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_capture_s = 1'b0;
        buf_clear_s   = 1'b0;
        load_req_s    = 1'b0;
        load_tgt_s    = redirect_target_i;
        mis_d         = 1'b0;
        bad_d         = bad_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (trap_i) begin
                    pc_d        = TRAP_VEC;
                    buf_clear_s = 1'b1;
                end else if (redirect_valid_i) begin
                    if (stall_i) begin
                        buf_capture_s = 1'b1;
                        state_d       = HOLD;
                    end else begin
                        load_req_s = 1'b1;
                    end
                end else if (!stall_i) begin
                    pc_d = pc_q + PC_INC_W;
                end else begin
                    pc_d = pc_q;
                end
            end
            HOLD: begin
                if (trap_i) begin
                    pc_d        = TRAP_VEC;
                    buf_clear_s = 1'b1;
                    state_d     = RUN;
                end else if (!stall_i) begin
                    load_req_s  = 1'b1;
                    load_tgt_s  = buf_target_s;
                    buf_clear_s = 1'b1;
                    state_d     = RUN;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_VEC;
            end
        endcase

        if (load_req_s) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (load_tgt_s[1:0] != 2'b00) begin
                pc_d  = TRAP_VEC;
                mis_d = 1'b1;
                bad_d = load_tgt_s;
            end else begin
                pc_d = load_tgt_s;
            end
`else
            pc_d  = load_tgt_s & ALIGN_MASK;
            bad_d = {XLEN{1'b0}};
`endif
        end else begin
            mis_d = 1'b0;
        end
    end

    // All PC-side state: FSM, fetch PC, misalign pulse and captured bad address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            mis_q   <= 1'b0;
            bad_q   <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            bad_q   <= bad_d;
        end
    end

    assign pc_o               = pc_q;
    assign pc_valid_o         = (state_q == RUN);
    assign pc_plus4_o         = pc_q + PC_INC_W;
    assign redirect_pending_o = buf_valid_s;
    assign misalign_o         = mis_q;
    assign bad_addr_o         = bad_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// checked against a queue-based reference model. Honours PC_MISALIGN_TRAP_EN.
module tb_pc_gen;

    localparam logic [31:0] RST_V  = 32'h0000_0000;
    localparam logic [31:0] TRAP_V = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic        trap_i = 1'b0;
    logic [31:0] redirect_target_i = 32'h0;
    logic [31:0] pc_o, pc_plus4_o, bad_addr_o;
    logic        pc_valid_o, redirect_pending_o, misalign_o;

    pc_gen #(.XLEN(32), .RESET_VEC(RST_V), .TRAP_VEC(TRAP_V)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .trap_i            (trap_i),
        .pc_o              (pc_o),
        .pc_valid_o        (pc_valid_o),
        .pc_plus4_o        (pc_plus4_o),
        .redirect_pending_o(redirect_pending_o),
        .misalign_o        (misalign_o),
        .bad_addr_o        (bad_addr_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: fetch address, boot flag, deferred-redirect queue.
    logic [31:0] m_pc, m_bad;
    bit          m_boot, m_mis;
    logic [31:0] m_pend[$];

    task automatic model_load(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) begin
            m_pc  = TRAP_V;
            m_mis = 1'b1;
            m_bad = t;
        end else begin
            m_pc = t;
        end
`else
        m_pc = {t[31:2], 2'b00};
`endif
    endtask

    task automatic model_edge(input bit st, input bit rv, input bit tr, input logic [31:0] tg);
        m_mis = 1'b0;
        if (m_boot) m_boot = 1'b0;
        else if (tr) begin
            m_pc = TRAP_V;
            m_pend.delete();
        end else if (m_pend.size() != 0) begin
            if (!st) model_load(m_pend.pop_front());
        end else if (rv) begin
            if (st) m_pend.push_back(tg);
            else model_load(tg);
        end else if (!st) m_pc = m_pc + 32'd4;
    endtask

    task automatic cycle(input bit st, input bit rv, input bit tr, input logic [31:0] tg);
        stall_i = st; redirect_valid_i = rv; trap_i = tr; redirect_target_i = tg;
        @(posedge clk);
        model_edge(st, rv, tr, tg);
        #1;
        stall_i = 1'b0; redirect_valid_i = 1'b0; trap_i = 1'b0;
    endtask

    task automatic reset_model();
        m_pc = RST_V; m_bad = 32'h0; m_boot = 1'b1; m_mis = 1'b0;
        m_pend.delete();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reset_model();
        #2;
        n_tests++;
        if ({pc_o, pc_valid_o, redirect_pending_o, misalign_o, bad_addr_o} !== {RST_V, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state got pc=%h v=%b pend=%b mis=%b bad=%h exp pc=%h v=0 pend=0 mis=0 bad=0",
                     pc_o, pc_valid_o, redirect_pending_o, misalign_o, bad_addr_o, RST_V);
        end
        release_reset();
    endtask

    task automatic test_boot();
        n_tests++;
        if ({pc_o, pc_valid_o} !== {32'h0, 1'b0}) begin
            n_fail++; $display("FAIL boot_c1 got pc=%h v=%b exp pc=00000000 v=0", pc_o, pc_valid_o);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        n_tests++;
        if ({pc_o, pc_valid_o, pc_plus4_o} !== {32'h0, 1'b1, 32'h4}) begin
            n_fail++; $display("FAIL boot_c2 got pc=%h v=%b p4=%h exp pc=00000000 v=1 p4=00000004", pc_o, pc_valid_o, pc_plus4_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pc_o, pc_valid_o} !== {32'h4, 1'b1}) begin
            n_fail++; $display("FAIL boot_c3 got pc=%h v=%b exp pc=00000004 v=1", pc_o, pc_valid_o);
        end
    endtask

    task automatic test_redirect();
        cycle(1'b0, 1'b1, 1'b0, 32'h40);
        cycle(1'b0, 1'b1, 1'b0, 32'h200);
        n_tests++;
        if ({pc_o, pc_valid_o} !== {32'h200, 1'b1}) begin
            n_fail++; $display("FAIL redirect_load got pc=%h v=%b exp pc=00000200 v=1", pc_o, pc_valid_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if (pc_o !== 32'h204) begin
            n_fail++; $display("FAIL redirect_inc got pc=%h exp 00000204", pc_o);
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b1, 1'b0, 32'h40);
        cycle(1'b1, 1'b1, 1'b0, 32'h300);
        n_tests++;
        if ({pc_o, pc_valid_o, redirect_pending_o} !== {32'h40, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL hold_enter got pc=%h v=%b pend=%b exp pc=00000040 v=0 pend=1", pc_o, pc_valid_o, redirect_pending_o);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h500);
        n_tests++;
        if ({pc_o, redirect_pending_o} !== {32'h40, 1'b1}) begin
            n_fail++; $display("FAIL hold_second got pc=%h pend=%b exp pc=00000040 pend=1", pc_o, redirect_pending_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pc_o, pc_valid_o, redirect_pending_o} !== {32'h300, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL hold_release got pc=%h v=%b pend=%b exp pc=00000300 v=1 pend=0", pc_o, pc_valid_o, redirect_pending_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if (pc_o !== 32'h304) begin
            n_fail++; $display("FAIL hold_after got pc=%h exp 00000304", pc_o);
        end
    endtask

    task automatic test_trap_in_hold();
        cycle(1'b1, 1'b1, 1'b0, 32'h300);
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        n_tests++;
        if ({pc_o, pc_valid_o, redirect_pending_o} !== {TRAP_V, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL trap_hold got pc=%h v=%b pend=%b exp pc=%h v=1 pend=0", pc_o, pc_valid_o, redirect_pending_o, TRAP_V);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if (pc_o !== 32'h104) begin
            n_fail++; $display("FAIL trap_after got pc=%h exp 00000104", pc_o);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        n_tests++;
        if ({pc_o, pc_plus4_o} !== {32'hFFFF_FFFC, 32'h0}) begin
            n_fail++; $display("FAIL wrap_p4 got pc=%h p4=%h exp pc=fffffffc p4=00000000", pc_o, pc_plus4_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if (pc_o !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pc got pc=%h exp 00000000", pc_o);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] e_pc1, e_bad1, e_pc2, e_bad2;
        logic        e_mis;
`ifdef PC_MISALIGN_TRAP_EN
        e_pc1 = TRAP_V;   e_bad1 = 32'h202; e_mis = 1'b1;
        e_pc2 = TRAP_V;   e_bad2 = 32'h306;
`else
        e_pc1 = 32'h200;  e_bad1 = 32'h0;   e_mis = 1'b0;
        e_pc2 = 32'h304;  e_bad2 = 32'h0;
`endif
        cycle(1'b0, 1'b1, 1'b0, 32'h202);
        n_tests++;
        if ({pc_o, misalign_o, bad_addr_o} !== {e_pc1, e_mis, e_bad1}) begin
            n_fail++; $display("FAIL misalign_run got pc=%h mis=%b bad=%h exp pc=%h mis=%b bad=%h", pc_o, misalign_o, bad_addr_o, e_pc1, e_mis, e_bad1);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({misalign_o, bad_addr_o} !== {1'b0, e_bad1}) begin
            n_fail++; $display("FAIL misalign_pulse got mis=%b bad=%h exp mis=0 bad=%h", misalign_o, bad_addr_o, e_bad1);
        end
        cycle(1'b1, 1'b1, 1'b0, 32'h306);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pc_o, misalign_o, bad_addr_o} !== {e_pc2, e_mis, e_bad2}) begin
            n_fail++; $display("FAIL misalign_hold got pc=%h mis=%b bad=%h exp pc=%h mis=%b bad=%h", pc_o, misalign_o, bad_addr_o, e_pc2, e_mis, e_bad2);
        end
    endtask

    task automatic test_reset_in_hold();
        cycle(1'b1, 1'b1, 1'b0, 32'h700);
        test_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pc_o, pc_valid_o, redirect_pending_o} !== {32'h4, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL reset_hold got pc=%h v=%b pend=%b exp pc=00000004 v=1 pend=0", pc_o, pc_valid_o, redirect_pending_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] tg;
        bit st, rv, tr, e_v, e_p;
        for (int i = 0; i < 400; i++) begin
            tg = $urandom;
            if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
            st = ($urandom_range(2) == 0);
            rv = ($urandom_range(3) == 0);
            tr = ($urandom_range(15) == 0);
            cycle(st, rv, tr, tg);
            e_v = !m_boot && (m_pend.size() == 0);
            e_p = (m_pend.size() != 0);
            n_tests++;
            if ({pc_o, pc_plus4_o, pc_valid_o, redirect_pending_o, misalign_o, bad_addr_o} !==
                {m_pc, m_pc + 32'd4, e_v, e_p, m_mis, m_bad}) begin
                n_fail++;
                $display("FAIL random_%0d got pc=%h p4=%h v=%b pend=%b mis=%b bad=%h exp pc=%h v=%b pend=%b mis=%b bad=%h",
                         i, pc_o, pc_plus4_o, pc_valid_o, redirect_pending_o, misalign_o, bad_addr_o,
                         m_pc, e_v, e_p, m_mis, m_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_redirect();
        test_hold();
        test_trap_in_hold();
        test_wrap();
        test_misalign();
        test_reset_in_hold();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
